// File: rtl/convolution.sv
// Streaming 3x3 RGB565 convolution: column window, registered products, then sum/shift/clamp.
// Define CONV_FRAME_LATCH_EN to load coefficients only at frame start (hcount 0, vcount 0).
module convolution #(
    parameter int HRES = 1280,
    parameter int VRES = 720,
    localparam int HW = $clog2(HRES),
    localparam int VW = $clog2(VRES)
) (
    input  logic                         clk_in,
    input  logic                         rst_n,
    input  logic [2:0][15:0]             data_in,
    input  logic                         data_valid_in,
    input  logic [HW-1:0]                hcount_in,
    input  logic [VW-1:0]                vcount_in,
    input  logic signed [2:0][2:0][7:0]  coeffs_in,
    input  logic signed [7:0]            shift_in,
    output logic [15:0]                  line_out,
    output logic [HW-1:0]                hcount_out,
    output logic [VW-1:0]                vcount_out,
    output logic                         data_valid_out
);

    logic [2:0][2:0][15:0]       win;      // [col][row], col 0 oldest
    logic signed [2:0][2:0][7:0] k_reg;
    logic signed [7:0]           s_reg;
    logic                        primed;
    logic                        v0, v1;
    logic [HW-1:0]               h0, h1;
    logic [VW-1:0]               vc0, vc1;
    logic [2:0][2:0][2:0][14:0]  prod, prod_nx;  // [channel][row][col]
    logic [4:0]                  sh1;
    logic signed [19:0]          acc, shr;
    logic [5:0]                  cl;
    logic [15:0]                 pix_nx;
    logic                        unused_shift;

    assign unused_shift = ^s_reg[6:5];

    function automatic logic signed [14:0] chan(input logic [15:0] p, input int ch);
        case (ch)
            0:       return 15'(p[15:11]);
            1:       return 15'(p[10:5]);
            default: return 15'(p[4:0]);
        endcase
    endfunction

    function automatic logic [5:0] clamp(input logic signed [19:0] x, input logic [5:0] mx);
        if (x < 20'sd0) return '0;
        if (x > $signed({14'b0, mx})) return mx;
        return x[5:0];
    endfunction

    // Window and input-side bookkeeping; nothing produces output until a line start is seen.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            win    <= '0;
            primed <= 1'b0;
            v0     <= 1'b0;
            h0     <= '0;
            vc0    <= '0;
        end else begin
            if (data_valid_in) begin
                if (hcount_in == '0) begin
                    win <= {data_in, data_in, data_in};
                end else begin
                    win[0] <= win[1];
                    win[1] <= win[2];
                    win[2] <= data_in;
                end
            end
            primed <= primed | (data_valid_in && hcount_in == '0);
            v0     <= data_valid_in && hcount_in != '0 && primed;
            h0     <= hcount_in - HW'(1);
            vc0    <= vcount_in;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            k_reg <= '0;
            s_reg <= '0;
        end else begin
`ifdef CONV_FRAME_LATCH_EN
            if (data_valid_in && hcount_in == '0 && vcount_in == '0) begin
                k_reg <= coeffs_in;
                s_reg <= shift_in;
            end
`else
            k_reg <= coeffs_in;
            s_reg <= shift_in;
`endif
        end
    end

    always_comb begin
        prod_nx = '0;
        for (int ch = 0; ch < 3; ch++)
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    prod_nx[ch][r][c] = chan(win[c][r], ch) * 15'($signed(k_reg[r][c]));
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            prod <= '0;
            sh1  <= '0;
            v1   <= 1'b0;
            h1   <= '0;
            vc1  <= '0;
        end else begin
            prod <= prod_nx;
            sh1  <= s_reg[7] ? 5'd0 : s_reg[4:0];
            v1   <= v0;
            h1   <= h0;
            vc1  <= vc0;
        end
    end

    always_comb begin
        acc    = '0;
        shr    = '0;
        cl     = '0;
        pix_nx = '0;
        for (int ch = 0; ch < 3; ch++) begin
            acc = '0;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    acc = acc + 20'($signed(prod[ch][r][c]));
            shr = acc >>> sh1;
            cl  = clamp(shr, (ch == 1) ? 6'd63 : 6'd31);
            case (ch)
                0:       pix_nx[15:11] = cl[4:0];
                1:       pix_nx[10:5]  = cl;
                default: pix_nx[4:0]   = cl[4:0];
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            line_out       <= '0;
            hcount_out     <= '0;
            vcount_out     <= '0;
            data_valid_out <= 1'b0;
        end else begin
            line_out       <= pix_nx;
            hcount_out     <= h1;
            vcount_out     <= vc1;
            data_valid_out <= v1;
        end
    end

endmodule

// File: tb/tb_convolution.sv
// Directed bench for convolution: behavioural model feeds a scoreboard, a monitor compares outputs.
module tb_convolution;

    logic                        clk_in = 1'b0;
    logic                        rst_n  = 1'b0;
    logic [2:0][15:0]            data_in = '0;
    logic                        data_valid_in = 1'b0;
    logic [10:0]                 hcount_in = '0;
    logic [9:0]                  vcount_in = '0;
    logic signed [2:0][2:0][7:0] coeffs_in = '0;
    logic signed [7:0]           shift_in = '0;
    logic [15:0]                 line_out;
    logic [10:0]                 hcount_out;
    logic [9:0]                  vcount_out;
    logic                        data_valid_out;

    always #5 clk_in = ~clk_in;

    convolution dut (
        .clk_in(clk_in), .rst_n(rst_n), .data_in(data_in), .data_valid_in(data_valid_in),
        .hcount_in(hcount_in), .vcount_in(vcount_in), .coeffs_in(coeffs_in), .shift_in(shift_in),
        .line_out(line_out), .hcount_out(hcount_out), .vcount_out(vcount_out),
        .data_valid_out(data_valid_out)
    );

    typedef struct {
        logic [15:0] pix;
        logic [10:0] h;
        logic [9:0]  v;
        int          cyc;
    } exp_t;

    exp_t             sb[$];
    int               errors = 0;
    int               checks = 0;
    int               cyc = 0;
    logic [2:0][15:0] m_win[3];
    bit               m_primed = 0;
    int               mk[3][3];
    int               ms = 0;
    int               ck[3][3];
    int               cs = 0;
    logic [2:0][15:0] col, last;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int chv(input logic [15:0] p, input int ch);
        case (ch)
            0:       return int'(p[15:11]);
            1:       return int'(p[10:5]);
            default: return int'(p[4:0]);
        endcase
    endfunction

    function automatic logic [15:0] model_pix();
        int sum, mx, sh;
        logic [15:0] px;
        px = '0;
        sh = (ms < 0) ? 0 : (ms & 31);
        for (int ch = 0; ch < 3; ch++) begin
            sum = 0;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    sum += chv(m_win[c][r], ch) * mk[r][c];
            sum = sum >>> sh;
            mx = (ch == 1) ? 63 : 31;
            if (sum < 0) sum = 0;
            if (sum > mx) sum = mx;
            if (ch == 0) px[15:11] = 5'(sum);
            else if (ch == 1) px[10:5] = 6'(sum);
            else px[4:0] = 5'(sum);
        end
        return px;
    endfunction

    task automatic drive(input logic [2:0][15:0] c, input int h, input int v,
                         input bit fx, input logic [15:0] fv);
        exp_t e;
        @(negedge clk_in);
        data_in = c;
        hcount_in = 11'(h);
        vcount_in = 10'(v);
        data_valid_in = 1'b1;
        for (int r = 0; r < 3; r++)
            for (int k = 0; k < 3; k++)
                coeffs_in[r][k] = 8'(ck[r][k]);
        shift_in = 8'(cs);
`ifdef CONV_FRAME_LATCH_EN
        if (h == 0 && v == 0) begin
            mk = ck;
            ms = cs;
        end
`else
        mk = ck;
        ms = cs;
`endif
        if (h == 0) begin
            m_win[0] = c; m_win[1] = c; m_win[2] = c;
        end else begin
            m_win[0] = m_win[1]; m_win[1] = m_win[2]; m_win[2] = c;
        end
        if (h != 0 && m_primed) begin
            e.pix = fx ? fv : model_pix();
            e.h   = 11'(h - 1);
            e.v   = 10'(v);
            e.cyc = cyc + 3;
            sb.push_back(e);
        end
        if (h == 0) m_primed = 1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk_in);
            data_valid_in = 1'b0;
        end
    endtask

    function automatic logic [2:0][15:0] rcol();
        return {16'($urandom), 16'($urandom), 16'($urandom)};
    endfunction

    always @(posedge clk_in) begin
        exp_t e;
        cyc++;
        #1;
        if (data_valid_out === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", {31'b0, data_valid_out}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("pixel", {16'b0, line_out}, {16'b0, e.pix});
                chk("hcount", {21'b0, hcount_out}, {21'b0, e.h});
                chk("vcount", {22'b0, vcount_out}, {22'b0, e.v});
                chk("latency_cycle", cyc, e.cyc);
            end
        end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            chk("missing_valid", {31'b0, data_valid_out}, 32'd1);
        end
    end

    initial begin
        ck = '{'{0, 0, 0}, '{0, 1, 0}, '{0, 0, 0}};
        cs = 0;
        for (int i = 0; i < 3; i++) m_win[i] = '0;
        mk = '{'{0, 0, 0}, '{0, 0, 0}, '{0, 0, 0}};
        repeat (2) @(negedge clk_in);
        chk("rst_line_out", {16'b0, line_out}, 32'd0);
        chk("rst_hcount", {21'b0, hcount_out}, 32'd0);
        chk("rst_vcount", {22'b0, vcount_out}, 32'd0);
        chk("rst_valid", {31'b0, data_valid_out}, 32'd0);
        rst_n = 1'b1;

        // identity with random data and gaps: output equals previous column's centre
        last = rcol();
        drive(last, 0, 0, 0, '0);
        for (int h = 1; h < 24; h++) begin
            col = rcol();
            drive(col, h, 0, 1, last[1]);
            last = col;
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(3);

        // gaussian on constant field, including replicated left edge
        ck = '{'{1, 2, 1}, '{2, 4, 2}, '{1, 2, 1}};
        cs = 4;
        for (int h = 0; h < 8; h++) drive({3{16'h8410}}, h, 0, 1, 16'h8410);
        idle(2);

        // sharpen: isolated bright centre saturates every channel
        ck = '{'{0, -1, 0}, '{-1, 5, -1}, '{0, -1, 0}};
        cs = 0;
        drive('0, 0, 0, 0, '0);
        drive({16'h0, 16'hFFFF, 16'h0}, 1, 0, 0, '0);
        drive('0, 2, 0, 1, 16'hFFFF);
        drive('0, 3, 0, 0, '0);
        idle(2);

        // sobel x: bright right column gives negative sums clamped to zero
        ck = '{'{1, 0, -1}, '{2, 0, -2}, '{1, 0, -1}};
        cs = 0;
        drive('0, 0, 0, 0, '0);
        drive('0, 1, 0, 0, '0);
        drive({3{16'hFFFF}}, 2, 0, 1, 16'h0000);
        drive('0, 3, 0, 0, '0);
        idle(2);

        // negative shift behaves as shift of zero
        ck = '{'{1, -2, 3}, '{-4, 5, -6}, '{7, -8, 9}};
        cs = -3;
        for (int h = 0; h < 6; h++) drive(rcol(), h, 0, 0, '0);
        idle(2);

        // asynchronous reset mid-line with traffic in flight
        ck = '{'{0, 0, 0}, '{0, 1, 0}, '{0, 0, 0}};
        cs = 0;
        for (int h = 0; h < 6; h++) drive(rcol(), h, 0, 0, '0);
        @(negedge clk_in);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_line_out", {16'b0, line_out}, 32'd0);
        chk("midrst_hcount", {21'b0, hcount_out}, 32'd0);
        chk("midrst_vcount", {22'b0, vcount_out}, 32'd0);
        chk("midrst_valid", {31'b0, data_valid_out}, 32'd0);
        sb.delete();
        for (int i = 0; i < 3; i++) m_win[i] = '0;
        m_primed = 0;
        mk = '{'{0, 0, 0}, '{0, 0, 0}, '{0, 0, 0}};
        ms = 0;
        @(negedge clk_in);
        rst_n = 1'b1;
        for (int h = 50; h < 54; h++) drive(rcol(), h, 0, 0, '0);
        idle(4);
        for (int h = 0; h < 6; h++) drive(rcol(), h, 0, 0, '0);
        idle(2);

        // coefficient switch mid-frame; frame-latched builds hold identity until next (0,0)
        ck = '{'{0, 0, 0}, '{0, 1, 0}, '{0, 0, 0}};
        cs = 0;
        for (int h = 0; h < 4; h++) drive(rcol(), h, 0, 0, '0);
        for (int h = 0; h < 110; h++) begin
            if (h == 100) begin
                ck = '{'{1, 2, 1}, '{2, 4, 2}, '{1, 2, 1}};
                cs = 4;
            end
            drive(rcol(), h, 5, 0, '0);
        end
        idle(2);
        for (int h = 0; h < 6; h++) drive(rcol(), h, 0, 0, '0);
        idle(6);

        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
